// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline control unit and its mult/div timer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned MD_TIMEOUT_DEF = 40;
    localparam int unsigned CNT_W_DEF      = 6;

endpackage

// File: rtl/pipeline_ctrl_md_timer.sv
// Saturating mult/div wait-cycle counter with a terminal-count flag.
module md_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // tc fires on the enabled cycle whose increment lands the count on MD_TIMEOUT-1.
    localparam logic [CNT_W-1:0] TC_PRE  = CNT_W'(MD_TIMEOUT - 2);

    logic [CNT_W-1:0] count_r;

    // Counter register: clear wins over enable, and the count never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = enable && (count_r == TC_PRE);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch control: load-use stalls, branch flushes and mult/div sequencing.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             dx_is_mult,
    input  logic             dx_is_div,
    input  logic             md_ready,
    input  logic             md_exception,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_bubble,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_error,
    output logic [CNT_W-1:0] md_cycles
);

    state_t           state_r;
    logic             err_r;
    logic             start_s;
    logic             tmr_clear_s;
    logic             tmr_en_s;
    logic             tc_s;
    logic [CNT_W-1:0] count_s;

    md_timer #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_md_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear_s),
        .enable (tmr_en_s),
        .count  (count_s),
        .tc     (tc_s)
    );

    assign md_cycles = count_s;

    // Latch controls and start pulses; reset forces the idle/run values.
    always_comb begin
        pc_en       = 1'b1;
        fd_en       = 1'b1;
        dx_en       = 1'b1;
        fd_flush    = 1'b0;
        dx_flush    = 1'b0;
        xm_bubble   = 1'b0;
        ctrl_mult   = 1'b0;
        ctrl_div    = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        md_error    = 1'b0;
        start_s     = 1'b0;
        tmr_clear_s = 1'b0;
        tmr_en_s    = 1'b0;
        if (reset) begin
            start_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Branch operands are not valid during a load-use stall.
                    if (hazard_stall) begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_en     = 1'b0;
                        xm_bubble = 1'b1;
                    end else if (branch_taken) begin
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (dx_is_mult || dx_is_div) begin
                        start_s     = 1'b1;
                        tmr_clear_s = 1'b1;
                        ctrl_mult   = dx_is_mult;
                        ctrl_div    = dx_is_div && !dx_is_mult;
                        pc_en       = 1'b0;
                        fd_en       = 1'b0;
                        dx_en       = 1'b0;
                        xm_bubble   = 1'b1;
                    end else begin
                        start_s = 1'b0;
                    end
                end
                ST_WAIT: begin
                    md_busy   = 1'b1;
                    tmr_en_s  = 1'b1;
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_en     = 1'b0;
                    xm_bubble = 1'b1;
                end
                ST_DONE: begin
                    md_done  = 1'b1;
                    md_error = err_r;
                end
                default: begin
                    start_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and sticky mult/div error latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= ST_WAIT;
                        err_r   <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        err_r   <= err_r;
                    end
                end
                ST_WAIT: begin
                    if (md_exception || tc_s) begin
                        err_r <= 1'b1;
                    end else begin
                        err_r <= err_r;
                    end
                    if (md_ready || tc_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    err_r   <= err_r;
                end
                default: begin
                    state_r <= ST_IDLE;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: per-cycle expected controls queued at drive time.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W = 6;

    // Input bundle bits: {reset, hazard_stall, branch_taken, dx_is_mult, dx_is_div, md_ready, md_exception}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_RST  = 7'b1000000;
    localparam logic [6:0] I_HZ   = 7'b0100000;
    localparam logic [6:0] I_BR   = 7'b0010000;
    localparam logic [6:0] I_MU   = 7'b0001000;
    localparam logic [6:0] I_DV   = 7'b0000100;
    localparam logic [6:0] I_RDY  = 7'b0000010;
    localparam logic [6:0] I_EXC  = 7'b0000001;

    // Output bundle bits: {pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_bubble,
    //                      ctrl_mult, ctrl_div, md_busy, md_done, md_error}
    localparam logic [10:0] O_RUN   = 11'b111_00_0_00_000;
    localparam logic [10:0] O_STALL = 11'b000_00_1_00_000;
    localparam logic [10:0] O_BR    = 11'b111_11_0_00_000;
    localparam logic [10:0] O_SMUL  = 11'b000_00_1_10_000;
    localparam logic [10:0] O_SDIV  = 11'b000_00_1_01_000;
    localparam logic [10:0] O_WAIT  = 11'b000_00_1_00_100;
    localparam logic [10:0] O_DOK   = 11'b111_00_0_00_010;
    localparam logic [10:0] O_DERR  = 11'b111_00_0_00_011;

    typedef struct {
        logic [10:0]      ctl;
        logic             chk_cyc;
        logic [CNT_W-1:0] cyc;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             hazard_stall;
    logic             branch_taken;
    logic             dx_is_mult;
    logic             dx_is_div;
    logic             md_ready;
    logic             md_exception;
    logic             pc_en;
    logic             fd_en;
    logic             dx_en;
    logic             fd_flush;
    logic             dx_flush;
    logic             xm_bubble;
    logic             ctrl_mult;
    logic             ctrl_div;
    logic             md_busy;
    logic             md_done;
    logic             md_error;
    logic [CNT_W-1:0] md_cycles;

    exp_t  sb[$];
    exp_t  cur;
    string phase = "init";
    int    n_cmp = 0;
    int    n_err = 0;

    pipeline_ctrl #(
        .MD_TIMEOUT (40),
        .CNT_W      (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .hazard_stall (hazard_stall),
        .branch_taken (branch_taken),
        .dx_is_mult   (dx_is_mult),
        .dx_is_div    (dx_is_div),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .dx_en        (dx_en),
        .fd_flush     (fd_flush),
        .dx_flush     (dx_flush),
        .xm_bubble    (xm_bubble),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .md_error     (md_error),
        .md_cycles    (md_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the controller must show in it.
    task automatic step(input logic [6:0] in_v, input logic [10:0] ctl,
                        input logic chk_c, input logic [CNT_W-1:0] cyc);
        exp_t e;
        {reset, hazard_stall, branch_taken, dx_is_mult, dx_is_div, md_ready, md_exception} = in_v;
        e.ctl     = ctl;
        e.chk_cyc = chk_c;
        e.cyc     = cyc;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Mid-cycle monitor: pops the expectation for this cycle and compares.
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk({phase, ".ctl"},
                {21'd0, pc_en, fd_en, dx_en, fd_flush, dx_flush, xm_bubble,
                 ctrl_mult, ctrl_div, md_busy, md_done, md_error},
                {21'd0, cur.ctl});
            if (cur.chk_cyc) begin
                chk({phase, ".cycles"}, {26'd0, md_cycles}, {26'd0, cur.cyc});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {reset, hazard_stall, branch_taken, dx_is_mult, dx_is_div, md_ready, md_exception} = I_RST;
        @(posedge clock);
        #1;

        phase = "reset";
        step(I_RST, O_RUN, 1'b1, 6'd0);
        step(I_RST, O_RUN, 1'b1, 6'd0);
        step(I_NONE, O_RUN, 1'b1, 6'd0);

        phase = "loaduse";
        step(I_HZ, O_STALL, 1'b0, 6'd0);
        step(I_NONE, O_RUN, 1'b0, 6'd0);

        phase = "stall_br";
        step(I_HZ | I_BR, O_STALL, 1'b0, 6'd0);
        step(I_BR, O_BR, 1'b0, 6'd0);
        step(I_NONE, O_RUN, 1'b0, 6'd0);

        // mul with a same-cycle ready that must be ignored, then ready at WAIT cycle 17
        phase = "mul17";
        step(I_MU | I_RDY, O_SMUL, 1'b0, 6'd0);
        for (int k = 1; k <= 17; k++) begin
            step(I_MU | ((k == 17) ? I_RDY : I_NONE) | ((k == 3) ? (I_HZ | I_BR) : I_NONE),
                 O_WAIT, 1'b0, 6'd0);
        end
        step(I_MU, O_DOK, 1'b1, 6'd17);
        step(I_NONE, O_RUN, 1'b1, 6'd17);

        phase = "mulwins";
        step(I_MU | I_DV, O_SMUL, 1'b0, 6'd0);
        step(I_MU | I_DV | I_RDY, O_WAIT, 1'b0, 6'd0);
        step(I_NONE, O_DOK, 1'b1, 6'd1);

        phase = "div_exc";
        step(I_DV, O_SDIV, 1'b0, 6'd0);
        for (int k = 1; k <= 33; k++) begin
            step(I_DV | ((k == 5) ? I_EXC : I_NONE) | ((k == 33) ? I_RDY : I_NONE),
                 O_WAIT, 1'b0, 6'd0);
        end
        step(I_DV, O_DERR, 1'b1, 6'd33);
        step(I_NONE, O_RUN, 1'b1, 6'd33);

        phase = "timeout";
        step(I_MU, O_SMUL, 1'b0, 6'd0);
        for (int k = 1; k <= 39; k++) begin
            step(I_MU, O_WAIT, 1'b0, 6'd0);
        end
        step(I_MU, O_DERR, 1'b1, 6'd39);
        step(I_NONE, O_RUN, 1'b1, 6'd39);

        // reset at WAIT cycle 10 after an exception; the restarted div must report no error
        phase = "reset_wait";
        step(I_DV, O_SDIV, 1'b0, 6'd0);
        for (int k = 1; k <= 9; k++) begin
            step(I_DV | ((k == 4) ? I_EXC : I_NONE), O_WAIT, 1'b0, 6'd0);
        end
        step(I_RST | I_DV, O_RUN, 1'b0, 6'd0);
        step(I_NONE, O_RUN, 1'b1, 6'd0);
        step(I_DV, O_SDIV, 1'b0, 6'd0);
        step(I_DV, O_WAIT, 1'b0, 6'd0);
        step(I_DV | I_RDY, O_WAIT, 1'b0, 6'd0);
        step(I_DV, O_DOK, 1'b1, 6'd2);
        step(I_NONE, O_RUN, 1'b1, 6'd2);

        phase = "drain";
        chk("drain.queue", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
